// File: rtl/edge_event_arbiter.sv
// Edge-capture front end with per-channel pending flags, drained one event at a time through a
// registered valid/ready slot under round-robin arbitration.

package sys_structs;
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_domain;
endpackage

module edge_event_arbiter #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  sys_structs::clk_domain clk_dom_i,
  input  logic                   en_i,
  input  logic [CHANNELS-1:0]    sense_i,
  input  logic [2*CHANNELS-1:0]  edge_sel_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [IDX_W-1:0]       evt_chan_o,
  output logic                   evt_rising_o,
  output logic [CHANNELS-1:0]    pending_o,
  output logic [CHANNELS-1:0]    overflow_o,
  input  logic [CHANNELS-1:0]    overflow_clr_i
);

  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] pol_q, pol_d;
  logic [CHANNELS-1:0] overflow_q, overflow_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0]    evt_chan_q, evt_chan_d;
  logic                evt_rising_q, evt_rising_d;

  logic [CHANNELS-1:0] sel_rise, sel_fall, rise, fall, hit;
  logic [CHANNELS-1:0] grant_oh, ovf_set;
  logic [IDX_W-1:0]    grant, cand;
  logic                found, load;

  // Edge detection against the enable-gated history.
  always_comb begin
    sel_rise = '0;
    sel_fall = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      sel_rise[c] = edge_sel_i[2*c];
      sel_fall[c] = edge_sel_i[2*c+1];
    end
    rise   = ~prev_q & sense_i;
    fall   = prev_q & ~sense_i;
    hit    = ((rise & sel_rise) | (fall & sel_fall)) & {CHANNELS{en_i}};
    prev_d = sense_i & {CHANNELS{en_i}};
  end

  // Round-robin search over registered pending flags, starting at rr_ptr_q.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand = IDX_W'((32'(rr_ptr_q) + i) % CHANNELS);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    load     = (~evt_valid_q | evt_ready_i) & found;
    grant_oh = '0;
    if (load) grant_oh[grant] = 1'b1;

    // A hit always leaves the channel pending; it only overflows if the old event stays behind.
    pending_d  = (pending_q & ~grant_oh) | hit;
    ovf_set    = hit & pending_q & ~grant_oh;
    overflow_d = (overflow_q & ~overflow_clr_i) | ovf_set;

    pol_d = pol_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (hit[c] && (!pending_q[c] || grant_oh[c])) pol_d[c] = sense_i[c];
    end

    rr_ptr_d     = rr_ptr_q;
    evt_valid_d  = evt_valid_q;
    evt_chan_d   = evt_chan_q;
    evt_rising_d = evt_rising_q;
    if (load) begin
      evt_valid_d  = 1'b1;
      evt_chan_d   = grant;
      evt_rising_d = pol_q[grant];
      rr_ptr_d     = (grant == IDX_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
    end else if (evt_valid_q && evt_ready_i) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_dom_i.clk) begin
    if (clk_dom_i.sync_rst) begin
      prev_q       <= '0;
      pending_q    <= '0;
      pol_q        <= '0;
      overflow_q   <= '0;
      rr_ptr_q     <= '0;
      evt_valid_q  <= 1'b0;
      evt_chan_q   <= '0;
      evt_rising_q <= 1'b0;
    end else if (clk_dom_i.clk_en) begin
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      pol_q        <= pol_d;
      overflow_q   <= overflow_d;
      rr_ptr_q     <= rr_ptr_d;
      evt_valid_q  <= evt_valid_d;
      evt_chan_q   <= evt_chan_d;
      evt_rising_q <= evt_rising_d;
    end
  end

  assign evt_valid_o  = evt_valid_q;
  assign evt_chan_o   = evt_chan_q;
  assign evt_rising_o = evt_rising_q;
  assign pending_o    = pending_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: hand-computed slot, pending and overflow state after
// each clock edge.

module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       sync_rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] sense = '0;
  logic [7:0] sel = '0;
  logic       ready = 1'b0;
  logic [3:0] ovf_clr = '0;

  logic       evt_valid;
  logic [1:0] evt_chan;
  logic       evt_rising;
  logic [3:0] pending;
  logic [3:0] overflow;

  sys_structs::clk_domain clk_dom;
  assign clk_dom = '{clk: clk, clk_en: clk_en, sync_rst: sync_rst};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  edge_event_arbiter #(.CHANNELS(4)) dut (
    .clk_dom_i     (clk_dom),
    .en_i          (en),
    .sense_i       (sense),
    .edge_sel_i    (sel),
    .evt_valid_o   (evt_valid),
    .evt_ready_i   (ready),
    .evt_chan_o    (evt_chan),
    .evt_rising_o  (evt_rising),
    .pending_o     (pending),
    .overflow_o    (overflow),
    .overflow_clr_i(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic v, input logic [1:0] c,
                              input logic r, input logic [3:0] p, input logic [3:0] o);
    check_eq({tag, ".valid"},    32'(evt_valid),  32'(v));
    check_eq({tag, ".chan"},     32'(evt_chan),   32'(c));
    check_eq({tag, ".rising"},   32'(evt_rising), 32'(r));
    check_eq({tag, ".pending"},  32'(pending),    32'(p));
    check_eq({tag, ".overflow"}, 32'(overflow),   32'(o));
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then reset again while gated with events pending.
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    expect_state("rst_init", 0, 0, 0, 4'h0, 4'h0);
    en = 1'b1; sel = 8'hFF; sense = 4'hF; ready = 1'b0;
    tick(); expect_state("pre_rst_pend", 0, 0, 0, 4'hF, 4'h0);
    tick(); expect_state("pre_rst_slot", 1, 0, 1, 4'hE, 4'h0);
    clk_en = 1'b0; sync_rst = 1'b1;
    tick(); expect_state("rst_gated", 0, 0, 0, 4'h0, 4'h0);
    sync_rst = 1'b0; clk_en = 1'b1;

    // Round-robin from a cleared pointer; ch0/ch3 falls arrive right after ch0 is granted.
    tick(); expect_state("rr_pend", 0, 0, 0, 4'hF, 4'h0);
    ready = 1'b1;
    tick(); expect_state("rr_c0", 1, 0, 1, 4'hE, 4'h0);
    sense = 4'h6;
    tick(); expect_state("rr_c1", 1, 1, 1, 4'hD, 4'h8);
    tick(); expect_state("rr_c2", 1, 2, 1, 4'h9, 4'h8);
    tick(); expect_state("rr_c3", 1, 3, 1, 4'h1, 4'h8);
    tick(); expect_state("rr_c0b", 1, 0, 0, 4'h0, 4'h8);
    tick(); expect_state("rr_empty", 0, 0, 0, 4'h0, 4'h8);
    ovf_clr = 4'h8;
    tick(); expect_state("ovf_clr3", 0, 0, 0, 4'h0, 4'h0);
    ovf_clr = 4'h0;

    // Single rising edge on ch2 (rise-only selection).
    sel = 8'h10; sense = 4'h0;
    tick(); expect_state("s_fall_ign", 0, 0, 0, 4'h0, 4'h0);
    sense = 4'h4;
    tick(); expect_state("s_pend", 0, 0, 0, 4'h4, 4'h0);
    tick(); expect_state("s_slot", 1, 2, 1, 4'h0, 4'h0);
    tick(); expect_state("s_drain", 0, 2, 1, 4'h0, 4'h0);

    // Backpressure and overflow on ch1.
    ready = 1'b0; sel = 8'h0C; sense = 4'h6;
    tick(); expect_state("bp_e1", 0, 2, 1, 4'h2, 4'h0);
    tick(); expect_state("bp_slot", 1, 1, 1, 4'h0, 4'h0);
    sense = 4'h4;
    tick(); expect_state("bp_e2", 1, 1, 1, 4'h2, 4'h0);
    sense = 4'h6;
    tick(); expect_state("bp_e3", 1, 1, 1, 4'h2, 4'h2);
    ovf_clr = 4'h2; sense = 4'h4;
    tick(); expect_state("bp_set_wins", 1, 1, 1, 4'h2, 4'h2);
    tick(); expect_state("bp_clr", 1, 1, 1, 4'h2, 4'h0);
    ovf_clr = 4'h0; ready = 1'b1;
    tick(); expect_state("bp_oldest", 1, 1, 0, 4'h0, 4'h0);
    tick(); expect_state("bp_empty", 0, 1, 0, 4'h0, 4'h0);

    // Grant and new hit on ch0 in the same cycle.
    sel = 8'h03; sense = 4'h5;
    tick(); expect_state("gc_pend", 0, 1, 0, 4'h1, 4'h0);
    sense = 4'h4;
    tick(); expect_state("gc_collide", 1, 0, 1, 4'h1, 4'h0);
    tick(); expect_state("gc_second", 1, 0, 0, 4'h0, 4'h0);

    // Clock-enable gating: ready high, slot valid, nothing may move.
    clk_en = 1'b0; sense = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_state($sformatf("gate%0d", i), 1, 0, 0, 4'h0, 4'h0);
    end
    clk_en = 1'b1; sense = 4'h4;
    tick(); expect_state("gate_release", 0, 0, 0, 4'h0, 4'h0);

    // Capture disabled: toggling sense creates nothing; enabling with sense high is a rise.
    en = 1'b0; sel = 8'hFF;
    sense = 4'hF; tick(); expect_state("dis_f", 0, 0, 0, 4'h0, 4'h0);
    sense = 4'h0; tick(); expect_state("dis_0", 0, 0, 0, 4'h0, 4'h0);
    sense = 4'hA; tick(); expect_state("dis_a", 0, 0, 0, 4'h0, 4'h0);
    en = 1'b1;
    tick(); expect_state("en_rise", 0, 0, 0, 4'hA, 4'h0);
    tick(); expect_state("en_c1", 1, 1, 1, 4'h8, 4'h0);
    tick(); expect_state("en_c3", 1, 3, 1, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
